// File: rtl/queue_pkg.sv
// Shared types for queue_burst_reader: FSM state and burst close cause.
package queue_pkg;

    typedef enum logic {QBR_IDLE, QBR_HOLD} qbr_state_e;

    typedef enum logic [1:0] {NONE, FULL, FLUSH, TMO} qbr_close_e;

endpackage

// File: rtl/qbr_idle_timer.sv
// Saturating idle-cycle counter; expired is high once the count reaches TIMEOUT.
module qbr_idle_timer #(
    parameter int TIMEOUT = 16,
    parameter int TCNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [TCNT_W-1:0] cnt_q;

    assign expired = (cnt_q == TCNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/queue_burst_reader.sv
// Drains a show-ahead queue into a framed valid/ready stream with out_last.
// Optional QUEUE_BURST_READER_STATS_EN adds burst_cnt / tmo_cnt outputs.
module queue_burst_reader
    import queue_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 16,
    parameter int BCNT_W     = $clog2(BURST_LEN),
    parameter int TCNT_W     = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  q_empty,
    input  logic [DATA_WIDTH-1:0] q_data,
    output logic                  q_deq_ready,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy
`ifdef QUEUE_BURST_READER_STATS_EN
    ,
    output logic [15:0]           burst_cnt,
    output logic [15:0]           tmo_cnt
`endif
);

    qbr_state_e            state_q, state_d;
    qbr_close_e            cause;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] out_data_d;
    logic                  out_valid_d, out_last_d;
    logic [BCNT_W-1:0]     beat_q, beat_d;
    logic                  can_move, pop, expired;

    assign can_move    = !out_valid || out_ready;
    assign pop         = rst_n && !q_empty && !flush && (state_q == QBR_IDLE || can_move);
    assign q_deq_ready = pop;
    assign busy        = (state_q == QBR_HOLD) || out_valid;

    qbr_idle_timer #(
        .TIMEOUT(TIMEOUT),
        .TCNT_W (TCNT_W)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (pop),
        .inc    (state_q == QBR_HOLD && !pop),
        .expired(expired)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        beat_d      = beat_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_last_d  = out_last;
        cause       = NONE;

        if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (state_q == QBR_IDLE) begin
            if (pop) begin
                hold_d  = q_data;
                state_d = QBR_HOLD;
            end
        end else if (can_move) begin
            // Close causes outrank a plain pop, except timeout, which only fires when nothing arrives.
            if (beat_q == BCNT_W'(BURST_LEN - 1)) begin
                cause = FULL;
            end else if (flush) begin
                cause = FLUSH;
            end else if (pop) begin
                out_valid_d = 1'b1;
                out_data_d  = hold_q;
                out_last_d  = 1'b0;
                beat_d      = beat_q + 1'b1;
                hold_d      = q_data;
            end else if (expired) begin
                cause = TMO;
            end

            if (cause != NONE) begin
                out_valid_d = 1'b1;
                out_data_d  = hold_q;
                out_last_d  = 1'b1;
                beat_d      = '0;
                if (pop) begin
                    hold_d = q_data;
                end else begin
                    state_d = QBR_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= QBR_IDLE;
            hold_q    <= '0;
            beat_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            beat_q    <= beat_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_last  <= out_last_d;
        end
    end

`ifdef QUEUE_BURST_READER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (out_valid && out_ready && out_last) begin
                burst_cnt <= burst_cnt + 16'd1;
            end
            if (cause == TMO) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_queue_burst_reader.sv
// Directed self-checking bench for queue_burst_reader (default and BURST_LEN=2 instances).
module tb_queue_burst_reader;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        out_ready;
    logic        q_empty, q_deq_ready;
    logic [15:0] q_data;
    logic        out_valid, out_last, busy;
    logic [15:0] out_data;

    logic        q_empty2, q_deq_ready2, out_ready2;
    logic [15:0] q_data2;
    logic        out_valid2, out_last2, busy2;
    logic [15:0] out_data2;

`ifdef QUEUE_BURST_READER_STATS_EN
    logic [15:0] burst_cnt, tmo_cnt, burst_cnt2, tmo_cnt2;
`endif

    always #5 clk = ~clk;

    // Queue model: show-ahead FIFO filled by the stimulus, popped on q_deq_ready.
    logic [15:0] mem [64];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    int          pop_cnt = 0;
    int          cyc = 0;
    int          last_pop_edge = 0;
    logic [15:0] src2 = '0;

    assign q_empty = (wr_ptr == rd_ptr);
    assign q_data  = mem[rd_ptr[5:0]];
    assign q_data2 = 16'h1111 + src2;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (q_deq_ready) begin
            rd_ptr        <= rd_ptr + 1;
            pop_cnt       <= pop_cnt + 1;
            last_pop_edge <= cyc + 1;
        end
        if (q_deq_ready2) begin
            src2 <= src2 + 16'd1;
        end
    end

    // Capture accepted beats; sampled on the falling edge ahead of the accepting rising edge.
    logic [15:0] cap_data [64];
    logic        cap_last [64];
    int          cap_edge [64];
    int          ncap = 0;
    logic [15:0] cap2_data [16];
    logic        cap2_last [16];
    int          cap2_edge [16];
    int          ncap2 = 0;

    always @(negedge clk) begin
        if (out_valid && out_ready && ncap < 64) begin
            cap_data[ncap] <= out_data;
            cap_last[ncap] <= out_last;
            cap_edge[ncap] <= cyc;
            ncap           <= ncap + 1;
        end
        if (out_valid2 && out_ready2 && ncap2 < 16) begin
            cap2_data[ncap2] <= out_data2;
            cap2_last[ncap2] <= out_last2;
            cap2_edge[ncap2] <= cyc;
            ncap2            <= ncap2 + 1;
        end
    end

    queue_burst_reader #(
        .DATA_WIDTH(16),
        .BURST_LEN (8),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .q_empty    (q_empty),
        .q_data     (q_data),
        .q_deq_ready(q_deq_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy)
`ifdef QUEUE_BURST_READER_STATS_EN
        ,
        .burst_cnt  (burst_cnt),
        .tmo_cnt    (tmo_cnt)
`endif
    );

    queue_burst_reader #(
        .DATA_WIDTH(16),
        .BURST_LEN (2),
        .TIMEOUT   (TIMEOUT)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .q_empty    (q_empty2),
        .q_data     (q_data2),
        .q_deq_ready(q_deq_ready2),
        .flush      (1'b0),
        .out_valid  (out_valid2),
        .out_data   (out_data2),
        .out_last   (out_last2),
        .out_ready  (out_ready2),
        .busy       (busy2)
`ifdef QUEUE_BURST_READER_STATS_EN
        ,
        .burst_cnt  (burst_cnt2),
        .tmo_cnt    (tmo_cnt2)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr++;
    endtask

    task automatic wait_beats(input bit second, input int n, input int budget, input string tag);
        int g = 0;
        while (((second ? ncap2 : ncap) < n) && g < budget) begin
            tick();
            g++;
        end
        check(tag, second ? ncap2 : ncap, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, p0, rbase;

        rst_n      = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        out_ready2 = 1'b1;
        q_empty2   = 1'b1;
        tick();
        tick();

        // Reset state, with queue already non-empty
        for (int i = 0; i < 8; i++) push(16'h0001 + 16'(i));
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_deq_ready", q_deq_ready, 0);
        check("rst_busy", busy, 0);

        // Eight words, one full burst
        base = ncap;
        p0   = pop_cnt;
        rst_n = 1'b1;
        wait_beats(0, base + 8, 60, "t1_beats");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_data%0d", i), cap_data[base + i], 16'h0001 + 16'(i));
            check($sformatf("t1_last%0d", i), cap_last[base + i], (i == 7) ? 1 : 0);
        end
        check("t1_pops", pop_cnt - p0, 8);
        check("t1_busy_low", busy, 0);
`ifdef QUEUE_BURST_READER_STATS_EN
        check("t1_burst_cnt", burst_cnt, 1);
`endif

        // Three words then empty: last word closes by timeout
        base = ncap;
        for (int i = 0; i < 3; i++) push(16'h00A0 + 16'(i));
        wait_beats(0, base + 3, 60, "t2_beats");
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_data%0d", i), cap_data[base + i], 16'h00A0 + 16'(i));
            check($sformatf("t2_last%0d", i), cap_last[base + i], (i == 2) ? 1 : 0);
        end
        check("t2_tmo_latency", cap_edge[base + 2] - last_pop_edge, TIMEOUT + 1);
`ifdef QUEUE_BURST_READER_STATS_EN
        check("t2_tmo_cnt", tmo_cnt, 1);
`endif

        // Backpressure: only two words in flight while stalled
        base = ncap;
        p0   = pop_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(16'h00B0 + 16'(i));
        repeat (20) tick();
        check("t3_stall_pops", pop_cnt - p0, 2);
        check("t3_stall_valid", out_valid, 1);
        check("t3_stall_data", out_data, 16'h00B0);
        check("t3_stall_deq", q_deq_ready, 0);
        out_ready = 1'b1;
        wait_beats(0, base + 10, 100, "t3_beats");
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t3_data%0d", i), cap_data[base + i], 16'h00B0 + 16'(i));
            check($sformatf("t3_last%0d", i), cap_last[base + i], (i == 7 || i == 9) ? 1 : 0);
        end

        // Flush with H at beat 2, then a fresh full burst
        base = ncap;
        for (int i = 0; i < 3; i++) push(16'h00C0 + 16'(i));
        for (int i = 0; i < 8; i++) push(16'h00D0 + 16'(i));
        tick();
        tick();
        tick();
        flush = 1'b1;
        p0    = pop_cnt;
        tick();
        flush = 1'b0;
        check("t4_flush_valid", out_valid, 1);
        check("t4_flush_data", out_data, 16'h00C2);
        check("t4_flush_last", out_last, 1);
        check("t4_flush_nopop", pop_cnt - p0, 0);
        wait_beats(0, base + 11, 80, "t4_beats");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_data%0d", i), cap_data[base + 3 + i], 16'h00D0 + 16'(i));
            check($sformatf("t4_last%0d", i), cap_last[base + 3 + i], (i == 7) ? 1 : 0);
        end

        // Reset pulsed mid-burst at beat 5
        base = ncap;
        for (int i = 0; i < 14; i++) push(16'h00E0 + 16'(i));
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_deq", q_deq_ready, 0);
        check("t5_pre_rst_beats", ncap - base, 4);
        tick();
        tick();
        check("t5_rst_deq_hold", q_deq_ready, 0);
        rbase = ncap;
        rst_n = 1'b1;
        wait_beats(0, rbase + 8, 60, "t5_beats");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t5_data%0d", i), cap_data[rbase + i], 16'h00E6 + 16'(i));
            check($sformatf("t5_last%0d", i), cap_last[rbase + i], (i == 7) ? 1 : 0);
        end

        // BURST_LEN=2 instance on a continuous stream
        q_empty2 = 1'b0;
        wait_beats(1, 10, 40, "t6_beats");
        q_empty2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t6_data%0d", i), cap2_data[i], 16'h1111 + 16'(i));
            check($sformatf("t6_last%0d", i), cap2_last[i], (i % 2 == 1) ? 1 : 0);
        end
        for (int i = 1; i < 10; i++) begin
            check($sformatf("t6_gap%0d", i), cap2_edge[i] - cap2_edge[i - 1], 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
